// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode map (MIPS funct field)
// and the status flag bundle carried alongside each result.
package alu_pkg;

  localparam logic [7:0] OP_SLL = 8'h00;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLT = 8'h2A;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  localparam int FLAGS_W = 4;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/opcode channel and result/flag channel of the pipelined ALU.
// slave is the ALU side, master is the source/consumer side.
interface alu_pipe_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [7:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result,
           out_zero, out_carry, out_overflow, out_illegal
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result,
           out_zero, out_carry, out_overflow, out_illegal
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and status flags for one operation.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  // Any shift amount of WIDTH or more pushes every bit out.
  function automatic logic [WIDTH-1:0] sll_sat(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] amt);
    logic [WIDTH-1:0] r;
    if (amt >= WLIM) r = '0;
    else             r = v << amt[SHW-1:0];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] srl_sat(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] amt);
    logic [WIDTH-1:0] r;
    if (amt >= WLIM) r = '0;
    else             r = v >> amt[SHW-1:0];
    return r;
  endfunction

  // Arithmetic shift saturates to a full copy of the sign bit.
  function automatic logic [WIDTH-1:0] sra_sat(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] amt);
    logic signed [WIDTH-1:0] sv;
    logic        [WIDTH-1:0] r;
    sv = signed'(v);
    if (amt >= WLIM) r = {WIDTH{v[WIDTH-1]}};
    else             r = sv >>> amt[SHW-1:0];
    return r;
  endfunction

  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          diff;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sa   = signed'(a);
  assign sb   = signed'(b);

  // Opcode decode; zero flag is derived from whatever result was selected.
  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result         = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SLL: result = sll_sat(a, b);
      OP_SRL: result = srl_sat(a, b);
      OP_SRA: result = sra_sat(a, b);
      OP_SLT: result = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: flags.illegal = 1'b1;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers operands, stage 2 registers
// the computed result and flags. Plain valid/ready on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  logic             vld_p1;
  logic             vld_p2;
  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [7:0]       op_p1;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flg_c;
  logic [WIDTH-1:0] res_p2;
  alu_flags_t       flg_p2;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv2         = !vld_p2 || bus.out_ready;
  assign adv1         = !vld_p1 || adv2;
  assign bus.in_ready = adv1;

  // ---- stage 1: operand capture ----

  // Stage-1 occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= bus.in_valid;
  end

  // Operand registers; contents only matter while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) begin
      a_p1  <= bus.in_a;
      b_p1  <= bus.in_b;
      op_p1 <= bus.in_op;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_p1),
    .b      (b_p1),
    .op     (op_p1),
    .result (res_c),
    .flags  (flg_c)
  );

  // ---- stage 2: result and flag registers ----

  // Stage-2 occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vld_p2 <= 1'b0;
    else if (adv2) vld_p2 <= vld_p1;
  end

  // Result and flags load together and hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p2 <= '0;
      flg_p2 <= '0;
    end else if (adv2 && vld_p1) begin
      res_p2 <= res_c;
      flg_p2 <= flg_c;
    end
  end

  assign bus.out_valid    = vld_p2;
  assign bus.out_result   = res_p2;
  assign bus.out_zero     = flg_p2.zero;
  assign bus.out_carry    = flg_p2.carry;
  assign bus.out_overflow = flg_p2.overflow;
  assign bus.out_illegal  = flg_p2.illegal;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 8-bit combinational ALU.
- Same MIPS-funct opcode map, plus two new ops (SLL, SLT).
- Adds valid/ready handshakes, registered result and status flags (zero/carry/overflow/illegal).
- Sits between the operand/opcode source (switch/UART front end) and the result consumer (display/TX); sustains one operation per clock under no back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits; legal for WIDTH >= 2.
- SHW, $clog2(WIDTH), localparam; number of low b bits examined as shift amount.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_a/in_b/in_op are valid.
- in_ready  out  1  stage 1 can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B / shift amount.
- in_op  in  8  opcode, MIPS funct encoding.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts this cycle.
- out_result  out  WIDTH  registered result.
- out_zero  out  1  result == 0.
- out_carry  out  1  ADD: carry-out; SUB: borrow (a < b unsigned); otherwise 0.
- out_overflow  out  1  signed overflow for ADD/SUB; otherwise 0.
- out_illegal  out  1  opcode not in the map.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): both stage valid bits clear; out_result = 0; all flags 0; out_valid = 0. Data in flight is discarded.
- Stage 1 captures a, b, op when in_valid && in_ready.
- Stage 2 computes and registers result plus flags from the stage-1 contents.
- Handshake:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from out_ready; no skid buffer)
  - Output transfer occurs on out_valid && out_ready.
- Latency: an input accepted in cycle N gives out_valid in N+2 when the pipe is not stalled. Throughput is 1 op/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_result and all flags hold stable, and stage 1 holds when it is full. No data is lost or duplicated.
- Simultaneous output drain and input accept in the same cycle is legal and keeps full throughput.
- Opcodes (a, b unsigned unless noted; all arithmetic modulo 2^WIDTH):
  - 0x20 ADD: a+b; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 0x22 SUB: a-b; carry = borrow.
  - 0x24 AND; 0x25 OR; 0x26 XOR.
  - 0x27 NOR = ~(a|b).
  - 0x00 SLL: a << b.
  - 0x02 SRL: logical right shift.
  - 0x03 SRA: arithmetic right shift, a treated as signed.
  - 0x2A SLT: 1 if signed a < signed b, else 0 (zero-extended).
- Shift saturation: if b >= WIDTH (any bit above SHW set, or value >= WIDTH), SLL and SRL give 0, and SRA gives all copies of a[WIDTH-1].
- Overflow:
  - ADD: a and b same sign, result sign differs.
  - SUB: a and b signs differ, result sign differs from a.
- Illegal opcode: result 0, out_zero = 1, out_illegal = 1, carry/overflow 0.
- out_zero is computed from the final result for every op.
- Flags are registered together with the result; they are meaningful only while out_valid = 1.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT
  - a flags struct/bundle width constant (4 bits: zero, carry, overflow, illegal)
- One natural sub-module: alu_core (purely combinational, WIDTH-parametrised result + flags), instantiated in stage 2.
- alu_pipe itself contains only the handshake and pipeline registers.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid drops immediately (async); result/flags read 0; in_ready=1 after release.
- WIDTH=8, back-to-back with out_ready=1 -> results two cycles after their inputs, one per cycle:
  - ADD 0x7F+0x01 -> 0x80, ovf=1, carry=0
  - ADD 0xFF+0x01 -> 0x00, zero=1, carry=1
  - SUB 0x00-0x01 -> 0xFF, carry=1
- Shifts at WIDTH=8:
  - SRA 0x80>>1 -> 0xC0
  - SRL 0x80>>1 -> 0x40
  - SRA 0x80 by 9 -> 0xFF
  - SLL 0x01 by 8 -> 0x00
  - NOR 0x0F,0xF0 -> 0x00, zero=1
  - SLT 0xFF,0x01 -> 0x01
- Back-pressure: hold out_ready=0 for 5 cycles while feeding 4 ops -> in_ready falls after two ops are held; outputs stable; release -> all 4 results delivered in order, no loss or duplicates.
- Illegal op 0x3F -> result 0x00, illegal=1, zero=1; followed immediately by ADD 2+3 -> 0x05, illegal=0.
- WIDTH=16 and WIDTH=32 regression with random ops, random in_valid/out_ready, checked against the reference model (scoreboard on transfers only).
